phase_detector_dd: RTL and testbench

Parametrised, pipelined decision-directed phase detector for the MSK/BPSK receive carrier loop. It runs at the sample clock and processes one symbol-centre sample per sym_valid. It supports three run-time-selectable error laws, rounding/saturation to the loop-filter width, first-symbol suppression and optional block averaging over 2^AVG_LOG2 symbols. Its output feeds the carrier-recovery loop filter.

---
 rtl/pd_pkg.sv | 52 +++++
 rtl/pd_mult_pipe.sv | 42 ++++
 rtl/phase_detector_dd.sv | 195 +++++++++++++++++++
 tb/tb_phase_detector_dd.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and helpers for the decision-directed phase detector.
//   pd_mode_t    : run-time error-law selection
//   sat_round    : round-half-up arithmetic shift plus symmetric-range clamp
//   MAX_AVG_LOG2 : largest supported averaging exponent
package pd_pkg;

  typedef enum logic [1:0] {
    PD_CROSS   = 2'd0,
    PD_BPSK_DD = 2'd1,
    PD_QPSK_DD = 2'd2,
    PD_RSVD    = 2'd3
  } pd_mode_t;

  localparam int unsigned MAX_AVG_LOG2 = 6;

  // Working width of sat_round; covers 2*IW+1+MAX_AVG_LOG2 plus rounding headroom
  // for any practical IW.
  localparam int unsigned PD_WMAX = 80;

  typedef struct packed {
    logic               sat;
    logic [PD_WMAX-1:0] val;
  } sat_round_t;

  // r = (value + 2^(shift-1)) >>> shift, then clamp to a signed ew-bit range.
  function automatic sat_round_t sat_round(input logic signed [PD_WMAX-1:0] value,
                                           input int unsigned shift,
                                           input int unsigned ew);
    logic signed [PD_WMAX-1:0] v;
    logic signed [PD_WMAX-1:0] hi;
    logic signed [PD_WMAX-1:0] lo;
    logic signed [PD_WMAX-1:0] one;
    sat_round_t                res;
    one = 1;
    v   = value;
    if (shift != 0) v = v + (one <<< (shift - 1));
    v  = v >>> shift;
    hi = (one <<< (ew - 1)) - one;
    lo = -(one <<< (ew - 1));
    res.sat = 1'b0;
    res.val = v;
    if (v > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (v < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/pd_mult_pipe.sv
// Pipelined signed multiplier with a valid bit carried alongside the data.
//   clk, rst  : clock, synchronous active-high reset (clears valid bits only)
//   in_valid  : operand qualifier
//   a, b      : signed operands
//   out_valid : qualifier delayed by PIPE cycles
//   p         : signed a*b, full AW+BW width, PIPE register stages after a/b
module pd_mult_pipe #(
  parameter int unsigned AW   = 16,
  parameter int unsigned BW   = 16,
  parameter int unsigned PIPE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic                    out_valid,
  output logic signed [AW+BW-1:0] p
);

  logic signed [AW+BW-1:0] p_q [PIPE];
  logic        [PIPE-1:0]  v_q;

  always_ff @(posedge clk) begin
    p_q[0] <= (AW+BW)'(a) * (AW+BW)'(b);
    for (int unsigned i = 1; i < PIPE; i++) begin
      p_q[i] <= p_q[i-1];
    end
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      for (int unsigned i = 1; i < PIPE; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign p         = p_q[PIPE-1];
  assign out_valid = v_q[PIPE-1];

endmodule

// File: rtl/phase_detector_dd.sv
// Pipelined decision-directed phase detector for the MSK/BPSK carrier loop.
//   clk       : sample clock
//   rst       : synchronous active-high reset
//   sym_valid : symbol-centre strobe (back-to-back allowed)
//   din_i/q   : signed IW-bit symbol-centre samples
//   mode      : 0 cross, 1 bpsk_dd, 2 qpsk_dd, 3 behaves as cross
//   err_valid : one-cycle pulse per new phase_err
//   phase_err : signed EW-bit error, rounded/saturated, held between pulses
//   err_sat   : set with err_valid when that result was clipped
// Pipeline: operand register, PIPE multiply stages, combine/round/saturate.
module phase_detector_dd
  import pd_pkg::*;
#(
  parameter int unsigned IW       = 16,
  parameter int unsigned EW       = 24,
  parameter int unsigned SHIFT    = 8,
  parameter int unsigned PIPE     = 3,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sym_valid,
  input  logic signed [IW-1:0] din_i,
  input  logic signed [IW-1:0] din_q,
  input  logic        [1:0]    mode,
  output logic                 err_valid,
  output logic signed [EW-1:0] phase_err,
  output logic                 err_sat
);

  localparam int unsigned PW   = 2 * IW;
  localparam int unsigned XW   = PW + 1;
  localparam int unsigned AW   = XW + AVG_LOG2;
  localparam int unsigned CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned S    = SHIFT + AVG_LOG2;
  localparam int unsigned NBLK = 1 << AVG_LOG2;

  localparam logic signed [IW-1:0] A_POS = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] A_NEG = {1'b1, {(IW-2){1'b0}}, 1'b1};

  // ---------------- stage 1: decision, operand mux, first-symbol logic
  pd_mode_t             m;
  logic                 mode_chg;
  logic                 is_cross;
  logic                 emit;
  logic signed [IW-1:0] sgn_i, sgn_q;
  logic signed [IW-1:0] a0, b0, a1, b1;

  logic signed [IW-1:0] prev_i, prev_q;
  logic                 prev_ok;
  logic        [1:0]    last_mode;

  logic signed [IW-1:0] s1_a0, s1_b0, s1_a1, s1_b1;
  logic                 s1_valid;
  logic                 s1_clr;

  assign m        = pd_mode_t'(mode);
  assign mode_chg = sym_valid && (mode != last_mode);
  assign sgn_i    = din_i[IW-1] ? A_NEG : A_POS;
  assign sgn_q    = din_q[IW-1] ? A_NEG : A_POS;

  // Every law is expressed as p0 - p1 so the combine stage is mode-agnostic.
  always_comb begin
    is_cross = 1'b0;
    a0 = din_i;
    b0 = prev_q;
    a1 = din_q;
    b1 = prev_i;
    case (m)
      PD_BPSK_DD: begin
        a0 = din_q;
        b0 = sgn_i;
        a1 = '0;
        b1 = '0;
      end
      PD_QPSK_DD: begin
        a0 = din_q;
        b0 = sgn_i;
        a1 = din_i;
        b1 = sgn_q;
      end
      default: is_cross = 1'b1;
    endcase
    // A mode change invalidates the stored symbol for the cross law.
    emit = sym_valid && (!is_cross || (prev_ok && !mode_chg));
  end

  always_ff @(posedge clk) begin
    s1_a0 <= a0;
    s1_b0 <= b0;
    s1_a1 <= a1;
    s1_b1 <= b1;
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_clr    <= 1'b0;
      prev_i    <= '0;
      prev_q    <= '0;
      prev_ok   <= 1'b0;
      last_mode <= PD_CROSS;
    end else begin
      s1_valid <= emit;
      s1_clr   <= mode_chg;
      if (sym_valid) begin
        prev_i    <= din_i;
        prev_q    <= din_q;
        prev_ok   <= 1'b1;
        last_mode <= mode;
      end
    end
  end

  // ---------------- multiply stages
  logic                 v0, v1;
  logic signed [PW-1:0] p0, p1;
  logic [PIPE-1:0]      clr_d;

  pd_mult_pipe #(.AW(IW), .BW(IW), .PIPE(PIPE)) u_mult0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .a         (s1_a0),
    .b         (s1_b0),
    .out_valid (v0),
    .p         (p0)
  );

  pd_mult_pipe #(.AW(IW), .BW(IW), .PIPE(PIPE)) u_mult1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .a         (s1_a1),
    .b         (s1_b1),
    .out_valid (v1),
    .p         (p1)
  );

  // The clear marker travels separately because a suppressed cross symbol
  // still has to reset the accumulator without producing a product.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_d <= '0;
    end else begin
      clr_d[0] <= s1_clr;
      for (int unsigned i = 1; i < PIPE; i++) begin
        clr_d[i] <= clr_d[i-1];
      end
    end
  end

  // ---------------- combine / accumulate / round / saturate
  logic                 fin_valid;
  logic                 clr_f;
  logic signed [XW-1:0] e;
  logic signed [AW-1:0] acc, acc_base, sum;
  logic        [CW-1:0] cnt, cnt_base;
  logic                 blk_last;
  sat_round_t           rs;

  assign fin_valid = v0 && v1;
  assign clr_f     = clr_d[PIPE-1];
  assign e         = XW'(p0) - XW'(p1);
  assign acc_base  = clr_f ? '0 : acc;
  assign cnt_base  = clr_f ? '0 : cnt;
  assign sum       = acc_base + AW'(e);
  assign blk_last  = (cnt_base == CW'(NBLK - 1));
  assign rs        = sat_round(PD_WMAX'(sum), S, EW);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      phase_err <= '0;
      err_sat   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      err_valid <= 1'b0;
      if (fin_valid) begin
        if (blk_last) begin
          err_valid <= 1'b1;
          phase_err <= rs.val[EW-1:0];
          err_sat   <= rs.sat;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_base + CW'(1);
        end
      end else if (clr_f) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_phase_detector_dd.sv
// Directed bench for phase_detector_dd. Three instances share one stimulus:
//   a: IW16 EW24 SHIFT8 PIPE3, no averaging
//   b: as a but EW12 (saturation)
//   c: as a but SHIFT0 AVG_LOG2=2 (block averaging)
// Pulses are captured 1 time unit after each posedge into per-instance queues.
module tb_phase_detector_dd;

  localparam int LAT = 5;  // PIPE+2 with PIPE=3

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sym_valid = 1'b0;
  logic signed [15:0] din_i = '0;
  logic signed [15:0] din_q = '0;
  logic        [1:0]  mode = 2'd0;

  logic               ev_a, ev_b, ev_c;
  logic signed [23:0] pe_a, pe_c;
  logic signed [11:0] pe_b;
  logic               sat_a, sat_b, sat_c;

  phase_detector_dd #(.IW(16), .EW(24), .SHIFT(8), .PIPE(3), .AVG_LOG2(0)) u_dut_a (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .din_i(din_i), .din_q(din_q),
    .mode(mode), .err_valid(ev_a), .phase_err(pe_a), .err_sat(sat_a));

  phase_detector_dd #(.IW(16), .EW(12), .SHIFT(8), .PIPE(3), .AVG_LOG2(0)) u_dut_b (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .din_i(din_i), .din_q(din_q),
    .mode(mode), .err_valid(ev_b), .phase_err(pe_b), .err_sat(sat_b));

  phase_detector_dd #(.IW(16), .EW(24), .SHIFT(0), .PIPE(3), .AVG_LOG2(2)) u_dut_c (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .din_i(din_i), .din_q(din_q),
    .mode(mode), .err_valid(ev_c), .phase_err(pe_c), .err_sat(sat_c));

  always #5 clk = ~clk;

  typedef struct {
    longint cyc;
    longint val;
    logic   sat;
  } pulse_t;

  pulse_t qa[$];
  pulse_t qb[$];
  pulse_t qc[$];
  longint cyc = 0;
  longint last_raise = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ev_a) qa.push_back('{cyc, longint'(pe_a), sat_a});
    if (ev_b) qb.push_back('{cyc, longint'(pe_b), sat_b});
    if (ev_c) qc.push_back('{cyc, longint'(pe_c), sat_c});
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sym(input int i, input int q, input int md);
    @(negedge clk);
    sym_valid  = 1'b1;
    din_i      = 16'(i);
    din_q      = 16'(q);
    mode       = 2'(md);
    last_raise = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  // Independent reference for the cross law at SHIFT=8, EW=24.
  function automatic longint exp_cross(input longint i, input longint q,
                                       input longint ip, input longint qp);
    longint e, r;
    e = i * qp - q * ip;
    r = (e + 128) >>> 8;
    if (r > 8388607) r = 8388607;
    if (r < -8388608) r = -8388608;
    return r;
  endfunction

  longint ri [20];
  longint rq [20];
  longint r2;
  int     gaps;

  initial begin
    // ---------------- reset state
    do_reset();
    @(posedge clk); #1;
    check("rst_valid", longint'(ev_a), 0);
    check("rst_err", longint'(pe_a), 0);
    check("rst_sat", longint'(sat_a), 0);

    // ---------------- cross, first-symbol suppression and latency
    do_reset();
    sym(1000, 0, 0);
    sym(0, 1000, 0);
    r2 = last_raise;
    idle(10);
    check("cross_cnt", qa.size(), 1);
    if (qa.size() >= 1) begin
      check("cross_val", qa[0].val, -3906);
      check("cross_sat", longint'(qa[0].sat), 0);
      check("cross_lat", qa[0].cyc - r2, LAT);
    end
    check("cross_hold", longint'(pe_a), -3906);

    // ---------------- saturation at EW=12
    do_reset();
    sym(0, -32768, 0);
    sym(32767, 0, 0);
    sym(32767, 0, 0);
    idle(10);
    check("sat_cnt", qb.size(), 2);
    if (qb.size() >= 2) begin
      check("sat_val", qb[0].val, -2048);
      check("sat_flag", longint'(qb[0].sat), 1);
      check("sat_next_val", qb[1].val, 0);
      check("sat_next_flag", longint'(qb[1].sat), 0);
    end

    // ---------------- bpsk_dd, no suppression
    do_reset();
    sym(-500, 300, 1);
    r2 = last_raise;
    idle(10);
    check("bpsk_cnt", qa.size(), 1);
    if (qa.size() >= 1) begin
      check("bpsk_val", qa[0].val, -38399);
      check("bpsk_lat", qa[0].cyc - r2, LAT);
    end

    // ---------------- averaging over 4 symbols
    do_reset();
    sym(100, 100, 1);
    sym(100, 200, 1);
    sym(100, 300, 1);
    idle(10);
    check("avg_partial", qc.size(), 0);
    sym(100, 400, 1);
    r2 = last_raise;
    idle(10);
    check("avg_cnt", qc.size(), 1);
    if (qc.size() >= 1) begin
      check("avg_val", qc[0].val, 8191750);
      check("avg_lat", qc[0].cyc - r2, LAT);
    end

    // ---------------- back-to-back throughput
    do_reset();
    for (int k = 0; k < 20; k++) begin
      ri[k] = longint'($signed(16'($urandom)));
      rq[k] = longint'($signed(16'($urandom)));
      sym(int'(ri[k]), int'(rq[k]), 0);
    end
    idle(10);
    check("stream_cnt", qa.size(), 19);
    for (int k = 1; k < 20; k++) begin
      if (k - 1 < qa.size())
        check($sformatf("stream_val%0d", k), qa[k-1].val,
              exp_cross(ri[k], rq[k], ri[k-1], rq[k-1]));
    end
    gaps = 0;
    for (int k = 1; k < qa.size(); k++) begin
      if (qa[k].cyc - qa[k-1].cyc != 1) gaps++;
    end
    check("stream_gapless", gaps, 0);

    // ---------------- reset mid-stream
    do_reset();
    for (int k = 0; k < 10; k++) sym(int'(ri[k]), int'(rq[k]), 0);
    @(negedge clk);
    rst = 1'b1;
    din_i = 16'sd777;
    din_q = -16'sd555;
    @(posedge clk); #1;
    check("midrst_valid", longint'(ev_a), 0);
    check("midrst_err", longint'(pe_a), 0);
    check("midrst_sat", longint'(sat_a), 0);
    @(negedge clk);
    rst = 1'b0;
    sym_valid = 1'b0;
    qa.delete();
    idle(10);
    check("midrst_stale", qa.size(), 0);
    sym(1234, -567, 0);
    idle(10);
    check("midrst_rearm", qa.size(), 0);
    sym(-2000, 3000, 0);
    idle(10);
    check("midrst_cnt", qa.size(), 1);
    if (qa.size() >= 1) check("midrst_val", qa[0].val, -10031);

    // ---------------- mode switches: cross -> qpsk_dd -> mode 3
    do_reset();
    sym(1000, 0, 0);
    sym(0, 1000, 0);
    sym(-500, 300, 2);
    sym(1000, 0, 3);
    sym(0, 1000, 3);
    idle(10);
    check("mode_cnt", qa.size(), 3);
    if (qa.size() >= 3) begin
      check("mode_cross", qa[0].val, -3906);
      check("mode_qpsk", qa[1].val, 25599);
      check("mode_rsvd", qa[2].val, -3906);
    end

    // ---------------- accumulator cleared on mode change
    do_reset();
    sym(100, 100, 1);
    sym(100, 200, 1);
    sym(0, 100, 2);
    sym(0, 200, 2);
    sym(0, 300, 2);
    sym(0, 400, 2);
    idle(10);
    check("avgclr_cnt", qc.size(), 1);
    if (qc.size() >= 1) check("avgclr_val", qc[0].val, 8191750);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
